addsub_serial: RTL and testbench
================================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal: 2..64).
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle (legal: 1..WIDTH, WIDTH mod DIGIT == 0).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand (minuend for subtract).
REQ-008 SHALL have port b  input  WIDTH  second operand (subtrahend for subtract).
REQ-009 SHALL have port mode  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result, carry and overflow are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  WIDTH  sum or difference.
REQ-013 SHALL have port carry  output  1  add: unsigned carry-out; subtract: borrow (1 iff a < b unsigned).
REQ-014 SHALL have port overflow  output  1  signed two's-complement overflow of the operation.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-016 In IDLE: in_ready = 1; on in_valid && in_ready, SHALL register a, b, mode, clear the digit counter, load carry-in = mode, and go to RUN.
REQ-017 In RUN: SHALL process one DIGIT-bit slice per cycle LSB-first, computing a + (b XOR {mode}) + carry-in, shifting the slice into result and keeping carry for the next slice.
REQ-018 SHALL leave RUN for DONE after exactly N RUN cycles; out_valid SHALL rise N cycles after the accepting edge.
REQ-019 carry SHALL equal final carry-out for add and its inverse for subtract; overflow SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-020 In DONE: out_valid = 1, result/carry/overflow held stable until out_valid && out_ready, then state returns to IDLE (in_ready = 1 the following cycle).
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes there SHALL be ignored.
REQ-022 out_ready while out_valid = 0 SHALL have no effect.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH (unless REQ-027 applies).

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, in_ready = 1 once released, out_valid = 0, result = 0, carry = 0, overflow = 0, counter = 0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation; no result is delivered for it.

Configuration
REQ-026 Macro ADDSUB_SERIAL_SAT_EN SHALL select signed saturation.
REQ-027 With ADDSUB_SERIAL_SAT_EN defined: on overflow, result SHALL be clamped at DONE entry to 0111..1 if the true result is positive, 1000..0 if negative; overflow still reports 1; carry unchanged.
REQ-028 Without ADDSUB_SERIAL_SAT_EN: result SHALL be the wrapped value and no clamp logic SHALL exist.

Structure
REQ-029 Package addsub_pkg SHALL hold the FSM state enum and constants MODE_ADD = 0, MODE_SUB = 1.
REQ-030 Sub-module addsub_digit SHALL implement the combinational DIGIT-bit ripple slice (a, b, mode, cin -> s, cout, c_into_msb); addsub_serial instantiates it once.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-031 add 0xFF+0x01 -> out_valid 8 cycles after accept, result 0x00, carry 1, overflow 0.
REQ-032 add 0x7F+0x01 -> result 0x80, carry 0, overflow 1; with SAT_EN result 0x7F.
REQ-033 sub 0x00-0x01 -> result 0xFF, carry(borrow) 1, overflow 0; sub 0x80-0x01 -> 0x7F, overflow 1, SAT_EN 0x80.
REQ-034 out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0; new in_valid ignored; after handshake in_ready 1 next cycle.
REQ-035 rst_n pulsed low at RUN cycle 3 -> out_valid stays 0, outputs 0, next accepted operation correct.
REQ-036 WIDTH=16, DIGIT=4, sub 0x1234-0x4321 -> out_valid 4 cycles after accept, result 0xCF13, carry 1, overflow 0.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pkg
//  Purpose  : Shared types and constants for the digit-serial adder/subtractor.
//             Holds the control FSM state encoding, the mode encodings and a
//             helper that sizes the digit counter.
//  Contents : state_t    - IDLE / RUN / DONE
//             MODE_ADD   - mode value selecting a + b
//             MODE_SUB   - mode value selecting a - b
//             cnt_width  - counter width for N digit steps (never below 1)
//  Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // A single-step operation still needs a 1-bit counter to keep the
    // comparison against N-1 well formed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_digit.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_digit
//  Purpose  : Combinational DIGIT-bit ripple slice computing
//             a + (b XOR {mode}) + cin. Subtraction is obtained by inverting
//             b and feeding cin = 1 on the first slice.
//  Ports    : a, b        in  [DIGIT-1:0] operand slices
//             mode        in  0 = add, 1 = subtract (inverts b)
//             cin         in  carry into the slice LSB
//             s           out [DIGIT-1:0] slice sum
//             cout        out carry out of the slice MSB
//             c_into_msb  out carry into the slice MSB (for signed overflow)
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_into_msb
);

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] b_eff;

    assign c[0]  = cin;
    assign b_eff = b ^ {DIGIT{mode}};

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            assign s[i]   = a[i] ^ b_eff[i] ^ c[i];
            assign c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
        end
    endgenerate

    assign cout       = c[DIGIT];
    assign c_into_msb = c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_serial
//  Purpose  : Digit-serial adder/subtractor with valid/ready handshakes.
//             Operands are captured in IDLE, processed DIGIT bits per cycle
//             LSB-first over N = WIDTH/DIGIT RUN cycles, then presented in
//             DONE until the consumer accepts them.
//  Config   : define ADDSUB_SERIAL_SAT_EN to clamp the result to the signed
//             range on overflow; without it the result wraps mod 2^WIDTH.
//  Ports    : clk        in  clock, rising edge
//             rst_n      in  asynchronous active-low reset
//             in_valid   in  operands and mode present
//             in_ready   out block can accept operands (IDLE)
//             a, b       in  [WIDTH-1:0] operands (a - b for subtract)
//             mode       in  0 = add, 1 = subtract
//             out_valid  out result/carry/overflow valid (DONE)
//             out_ready  in  consumer accepts the result
//             result     out [WIDTH-1:0] sum or difference
//             carry      out add: carry-out; subtract: borrow (a < b)
//             overflow   out signed two's-complement overflow
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    generate
        if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH ||
            (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("addsub_serial: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             mode_r;
    logic             cin_r;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0] d_s;
    logic             d_cout;
    logic             d_cmsb;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] result_raw;
    logic [WIDTH-1:0] result_final;
    logic             carry_final;
    logic             ovf_final;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(N - 1));

    // ------------------------------------------------------------------
    // Digit slice: always works on the low DIGIT bits of the shifting
    // operand registers.
    // ------------------------------------------------------------------
    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a          (a_sr[DIGIT-1:0]),
        .b          (b_sr[DIGIT-1:0]),
        .mode       (mode_r),
        .cin        (cin_r),
        .s          (d_s),
        .cout       (d_cout),
        .c_into_msb (d_cmsb)
    );

    // ------------------------------------------------------------------
    // Partial-sum accumulation. New slices enter at the top and move down,
    // so after N steps the first slice sits at the LSB. Only the upper
    // WIDTH-DIGIT bits need storage; the newest slice comes straight from
    // the digit adder.
    // ------------------------------------------------------------------
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign result_raw = d_s;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] part;

            assign result_raw = {d_s, part};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    part <= '0;
                end else if (state == RUN) begin
                    part <= result_raw[WIDTH-1:DIGIT];
                end
            end
        end
    endgenerate

    // Borrow is the inverse of the carry out of a + ~b + 1.
    assign carry_final = (mode_r == MODE_SUB) ? ~d_cout : d_cout;
    assign ovf_final   = d_cmsb ^ d_cout;

`ifdef ADDSUB_SERIAL_SAT_EN
    // Overflow only happens when both effective operands share a sign, so
    // the sign of a is the sign of the true (unbounded) result.
    logic a_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
        end
    end

    assign result_final = !ovf_final ? result_raw :
                          a_msb      ? {1'b1, {(WIDTH-1){1'b0}}} :
                                       {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign result_final = result_raw;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            mode_r   <= MODE_ADD;
            cin_r    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                mode_r <= mode;
                cin_r  <= mode;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> DIGIT;
                b_sr  <= b_sr >> DIGIT;
                cin_r <= d_cout;
                cnt   <= cnt + CNT_W'(1);
                if (last_step) begin
                    result   <= result_final;
                    carry    <= carry_final;
                    overflow <= ovf_final;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_serial
//  Purpose  : Self-checking bench for addsub_serial. Drives a WIDTH=8/DIGIT=1
//             instance and a WIDTH=16/DIGIT=4 instance, compares against an
//             arithmetic reference model, a directed vector table and
//             hand-written handshake/reset sequences.
//  Config   : honours ADDSUB_SERIAL_SAT_EN for expected saturated results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;

`ifdef ADDSUB_SERIAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv8, ir8, m8, ov8, or8, c8, o8;
    logic [7:0]  a8, b8, r8;
    logic        iv16, ir16, m16, ov16, or16, c16, o16;
    logic [15:0] a16, b16, r16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .mode      (m8),
        .out_valid (ov8),
        .out_ready (or8),
        .result    (r8),
        .carry     (c8),
        .overflow  (o8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .mode      (m16),
        .out_valid (ov16),
        .out_ready (or16),
        .result    (r16),
        .carry     (c16),
        .overflow  (o16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [7:0] r;
        logic       c;
        logic       o;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                  input logic tm, output logic [63:0] er,
                                  output logic ec, output logic eo);
        longint one, mask, ua, ub, sa, sb, t, mx, mn;
        one  = 1;
        mask = (one << w) - 1;
        ua   = longint'(ta) & mask;
        ub   = longint'(tb) & mask;
        sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        mx   = (one << (w - 1)) - 1;
        mn   = -(one << (w - 1));
        t    = tm ? sa - sb : sa + sb;
        eo   = (t > mx) || (t < mn);
        ec   = tm ? (ua < ub) : (((ua + ub) >> w) != 0);
        er   = 64'((tm ? ua - ub : ua + ub) & mask);
        if (SAT && eo) begin
            er = 64'((t > 0 ? mx : mn) & mask);
        end
    endfunction

    function automatic logic get_ir(input int sel);
        return sel ? ir16 : ir8;
    endfunction
    function automatic logic get_ov(input int sel);
        return sel ? ov16 : ov8;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [63:0] ta,
                         input logic [63:0] tb, input logic tm);
        if (sel != 0) begin
            iv16 = v; a16 = ta[15:0]; b16 = tb[15:0]; m16 = tm;
        end else begin
            iv8 = v; a8 = ta[7:0]; b8 = tb[7:0]; m8 = tm;
        end
    endtask

    // Accept one operation, check latency and results, complete the handshake.
    task automatic run_op(input int sel, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tm, input logic [63:0] er, input logic ec,
                          input logic eo, input string tag);
        int lat;
        int n;
        n = (sel != 0) ? 4 : 8;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(get_ir(sel)), 64'd1);
        drive(sel, 1'b1, ta, tb, tm);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 64'($urandom), 64'($urandom), 1'($urandom));
        lat = 0;
        while (!get_ov(sel) && lat < 40) begin
            // Activity on the input side while busy must be ignored.
            drive(sel, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            @(posedge clk);
            #1;
            lat++;
        end
        iv8  = 1'b0;
        iv16 = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(n));
        chk({tag, " in_ready_busy"}, 64'(get_ir(sel)), 64'd0);
        if (sel != 0) begin
            chk({tag, " result"}, 64'(r16), er & 64'hFFFF);
            chk({tag, " carry"}, 64'(c16), 64'(ec));
            chk({tag, " overflow"}, 64'(o16), 64'(eo));
        end else begin
            chk({tag, " result"}, 64'(r8), er & 64'hFF);
            chk({tag, " carry"}, 64'(c8), 64'(ec));
            chk({tag, " overflow"}, 64'(o8), 64'(eo));
        end
        @(negedge clk);
        if (sel != 0) or16 = 1'b1; else or8 = 1'b1;
        @(posedge clk);
        #1;
        or8  = 1'b0;
        or16 = 1'b0;
        chk({tag, " in_ready_after"}, 64'(get_ir(sel)), 64'd1);
        chk({tag, " out_valid_after"}, 64'(get_ov(sel)), 64'd0);
    endtask

    initial begin
        vec_t        vt[8];
        logic [63:0] er;
        logic        ec, eo;
        logic [63:0] ra, rb;
        logic        rm;
        logic        seen;
        int          lat;

        vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[1] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        vt[2] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[3] = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b0, 1'b1};
        vt[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vt[5] = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
        vt[6] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[7] = '{8'h7F, 8'hFF, 1'b1, SAT ? 8'h7F : 8'h80, 1'b1, 1'b1};

        iv8 = 0; a8 = 0; b8 = 0; m8 = 0; or8 = 0;
        iv16 = 0; a16 = 0; b16 = 0; m16 = 0; or16 = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(ir8), 64'd1);
        chk("reset out_valid", 64'(ov8), 64'd0);
        chk("reset result", 64'(r8), 64'd0);
        chk("reset carry", 64'(c8), 64'd0);
        chk("reset overflow", 64'(o8), 64'd0);
        chk("reset out_valid16", 64'(ov16), 64'd0);
        rst_n = 1'b1;

        // out_ready while idle has no effect
        @(negedge clk);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("idle out_ready out_valid", 64'(ov8), 64'd0);
        chk("idle out_ready in_ready", 64'(ir8), 64'd1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(0, 64'(vt[i].a), 64'(vt[i].b), vt[i].m, 64'(vt[i].r),
                   vt[i].c, vt[i].o, $sformatf("vec%0d", i));
        end

        // Wide/multi-bit digit case
        run_op(1, 64'h1234, 64'h4321, 1'b1, 64'hCF13, 1'b1, 1'b0, "w16 sub");

        // Randomised against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            rm = 1'($urandom);
            model(8, ra, rb, rm, er, ec, eo);
            run_op(0, ra, rb, rm, er, ec, eo, $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            ra = 64'($urandom_range(0, 65535));
            rb = 64'($urandom_range(0, 65535));
            rm = 1'($urandom);
            model(16, ra, rb, rm, er, ec, eo);
            run_op(1, ra, rb, rm, er, ec, eo, $sformatf("rnd16_%0d", i));
        end

        // Consumer stalls in DONE: outputs hold, new requests ignored
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h55; b8 = 8'h22; m8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("stall latency", 64'(lat), 64'd8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d out_valid", k), 64'(ov8), 64'd1);
            chk($sformatf("stall%0d result", k), 64'(r8), 64'h77);
            chk($sformatf("stall%0d carry", k), 64'(c8), 64'd0);
            chk($sformatf("stall%0d overflow", k), 64'(o8), 64'd0);
            chk($sformatf("stall%0d in_ready", k), 64'(ir8), 64'd0);
        end
        @(negedge clk);
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0;
        chk("stall release in_ready", 64'(ir8), 64'd1);
        chk("stall release out_valid", 64'(ov8), 64'd0);
        run_op(0, 64'h10, 64'h20, 1'b1, 64'hF0, 1'b1, 1'b0, "post-stall");

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F; m8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(ov8), 64'd0);
        chk("abort result", 64'(r8), 64'd0);
        chk("abort carry", 64'(c8), 64'd0);
        chk("abort overflow", 64'(o8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (ov8) seen = 1'b1;
        end
        chk("abort no result", 64'(seen), 64'd0);
        chk("abort in_ready", 64'(ir8), 64'd1);
        run_op(0, 64'h12, 64'h34, 1'b0, 64'h46, 1'b0, 1'b0, "post-abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
